// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receive side of a multiplexed 7-segment bus. Segments and anodes are both
//   active-low. Each digit glyph that stays stable long enough is decoded back
//   to a hex nibble. Once every digit has been captured, the rebuilt word is
//   published on hex_out. Intended uses are an on-chip loopback checker for the
//   display driver and a bench monitor.
//
//   Optional feature macro: SEG7_DEC_SYNC_EN
//     defined   - segments/anodes pass through a 2-flop synchronizer (reset
//                 value all-ones) before the sample register. This adds
//                 2 cycles of latency and allows an asynchronous source.
//     undefined - the inputs feed the sample register directly. The source
//                 must be in the clock domain.
//
// Parameters
//   STABLE_CYCLES  consecutive unchanged cycles of {anodes,segments} before capture (>=1)
//   NUM_DIGITS     number of digits; anodes width, hex_out = 4*NUM_DIGITS bits
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high, clears all state
//   segments     in   [6:0] active-low glyph, bit0=a .. bit6=g
//   anodes       in   [NUM_DIGITS-1:0] active-low digit select, bit i -> nibble i
//   hex_out      out  last complete reconstructed word
//   frame_valid  out  1-cycle pulse when hex_out updates
//   digit_error  out  1-cycle pulse when a non-hex glyph is captured
//   frame_count  out  completed frames, wraps 255 -> 0

module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              segments,
    input  logic [NUM_DIGITS-1:0]   anodes,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic                    frame_valid,
    output logic                    digit_error,
    output logic [7:0]              frame_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SMP_W = NUM_DIGITS + 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Glyph -> {legal, nibble}; anything outside the 16-glyph set is illegal.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h10:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    function automatic logic is_onehot_low(input logic [NUM_DIGITS-1:0] an);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) n++;
        end
        return (n == 1);
    endfunction

    // Only meaningful when exactly one anode is low.
    function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [SMP_W-1:0]        cur_smp;
    logic [SMP_W-1:0]        smp_p0;
    logic                    change;
    logic                    cur_onehot;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;

    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic [NUM_DIGITS-1:0]   cap_an;
    logic [6:0]              cap_seg;
    logic [IDX_W-1:0]        cap_idx;
    logic [4:0]              cap_dec;
    logic [NUM_DIGITS-1:0]   seen_set;
    logic [4*NUM_DIGITS-1:0] shadow_merged;

`ifdef SEG7_DEC_SYNC_EN
    logic [SMP_W-1:0] sync_p0, sync_p1;

    // Input synchronizer stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= {anodes, segments};
            sync_p1 <= sync_p0;
        end
    end

    assign cur_smp = sync_p1;
`else
    assign cur_smp = {anodes, segments};
`endif

    // Sample register: previous {anodes,segments}
    always_ff @(posedge clock or posedge reset) begin
        if (reset) smp_p0 <= '1;
        else       smp_p0 <= cur_smp;
    end

    assign change     = (cur_smp != smp_p0);
    assign cur_onehot = is_onehot_low(cur_smp[SMP_W-1:7]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cur_onehot) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!cur_onehot) begin
                    state_nxt = IDLE;
                end else if (change) begin
                    cnt_nxt = CNT_W'(1);
                end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // One capture per dwell: stay here until the bus moves.
                if (change) begin
                    if (cur_onehot) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In CAPTURE the sample register holds the value that was proven stable,
    // even if the live input has already moved on.
    always_comb begin
        cap_an        = smp_p0[SMP_W-1:7];
        cap_seg       = smp_p0[6:0];
        cap_idx       = low_index(cap_an);
        cap_dec       = decode_glyph(cap_seg);
        seen_set      = seen | (NUM_DIGITS'(1) << cap_idx);
        shadow_merged = shadow;
        shadow_merged[4*cap_idx +: 4] = cap_dec[3:0];
    end

    // Capture / frame assembly stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen        <= '0;
            shadow      <= '0;
            hex_out     <= '0;
            frame_valid <= 1'b0;
            digit_error <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_valid <= 1'b0;
            digit_error <= 1'b0;
            if (state == CAPTURE) begin
                if (cap_dec[4]) begin
                    shadow <= shadow_merged;
                    if (&seen_set) begin
                        hex_out     <= shadow_merged;
                        frame_valid <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        seen        <= '0;
                    end else begin
                        seen <= seen_set;
                    end
                end else begin
                    digit_error <= 1'b1;
                end
            end
        end
    end

endmodule
